// File: rtl/stitch_pkg.sv
// Shared state encoding and RWM direction constants for the stitcher sequencer.
// Imported by stitch_sequencer and phase_watchdog.
package stitch_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_CAPTURE = 3'd1;
  localparam state_t S_GAP     = 3'd2;
  localparam state_t S_GRAY    = 3'd3;
  localparam state_t S_READOUT = 3'd4;
  localparam state_t S_DONE    = 3'd5;
  localparam state_t S_ERROR   = 3'd6;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  // States in which a datapath unit is working and the watchdog runs.
  function automatic logic is_phase(state_t s);
    return (s == S_CAPTURE) || (s == S_GRAY) || (s == S_READOUT);
  endfunction

endpackage

// File: rtl/phase_watchdog.sv
// Per-phase cycle counter; expired is high in the last allowed phase cycle.
// Ports: clk, rst_n, clear, count_en -> expired.
module phase_watchdog
  import stitch_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int WD_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam logic [WD_W-1:0] LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] cnt_q;
  logic [WD_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (count_en && (cnt_q != LAST))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expired = count_en && (cnt_q == LAST);

endmodule

// File: rtl/stitch_sequencer.sv
// Frame sequencer: capture -> grayscale -> readout with watchdog and abort.
// Ports: start/abort/continuous, unit done inputs -> unit enables, status.
module stitch_sequencer
  import stitch_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int WD_W           = 16,
  parameter int FRAME_CNT_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   continuous,
  input  logic                   rwm1_done,
  input  logic                   gs_done,
  input  logic                   rwm2_done,
  output logic                   cam_enable,
  output logic                   rwm1_enable,
  output logic                   rwm1_rw,
  output logic                   gs_enable,
  output logic                   rwm2_enable,
  output logic                   rwm2_rw,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   error,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  state_t state_q, state_d;
  state_t next_q, next_d;
  logic [FRAME_CNT_W-1:0] fc_d;
  logic expired;
  logic in_phase;

  assign in_phase = is_phase(state_q);

  phase_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .WD_W          (WD_W)
  ) u_wd (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (!in_phase),
    .count_en(in_phase),
    .expired (expired)
  );

  always_comb begin
    state_d = state_q;
    next_d  = next_q;
    fc_d    = frame_count;
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:
          if (start) state_d = S_CAPTURE;
        S_CAPTURE:
          if (rwm1_done) begin
            state_d = S_GAP;
            next_d  = S_GRAY;
          end else if (expired) begin
            state_d = S_ERROR;
          end
        S_GAP:
          state_d = next_q;
        S_GRAY:
          if (gs_done) begin
            state_d = S_GAP;
            next_d  = S_READOUT;
          end else if (expired) begin
            state_d = S_ERROR;
          end
        S_READOUT:
          if (rwm2_done) begin
            state_d = S_DONE;
            fc_d    = frame_count + 1'b1;
          end else if (expired) begin
            state_d = S_ERROR;
          end
        S_DONE:
          if (continuous) begin
            state_d = S_GAP;
            next_d  = S_CAPTURE;
          end else begin
            state_d = S_IDLE;
          end
        S_ERROR:
          if (start) state_d = S_IDLE;
        default:
          state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      next_q      <= S_CAPTURE;
      frame_count <= '0;
    end else begin
      state_q     <= state_d;
      next_q      <= next_d;
      frame_count <= fc_d;
    end
  end

  // Outputs decode the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cam_enable  <= 1'b0;
      rwm1_enable <= 1'b0;
      rwm1_rw     <= 1'b0;
      gs_enable   <= 1'b0;
      rwm2_enable <= 1'b0;
      rwm2_rw     <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      error       <= 1'b0;
    end else begin
      cam_enable  <= (state_d == S_CAPTURE);
      rwm1_enable <= (state_d == S_CAPTURE) || (state_d == S_GRAY);
      rwm1_rw     <= (state_d == S_CAPTURE) ? RW_WRITE : RW_READ;
      gs_enable   <= (state_d == S_GRAY);
      rwm2_enable <= (state_d == S_GRAY) || (state_d == S_READOUT);
      rwm2_rw     <= (state_d == S_GRAY) ? RW_WRITE : RW_READ;
      busy        <= (state_d != S_IDLE) && (state_d != S_ERROR);
      frame_done  <= (state_d == S_DONE);
      error       <= (state_d == S_ERROR);
    end
  end

endmodule
